conv_frame_sequencer: RTL and testbench
=======================================

# conv_frame_sequencer

Frame-level controller for the rate-1/2 convolutional encoder datapath. Accepts a DATA_W-bit message on a start pulse and feeds it MSB-first, one bit per bit-tick, into the encoder. It then appends K-1 zero tail bits to flush the encoder, collects each 2-bit encoder output into a codeword buffer, and presents the finished codeword to the downstream decoder/channel stage with a valid/ready handshake. It replaces ad-hoc button/slow-clock sequencing with a single-clock, enable-based scheduler.

## Interface
- DATA_W, 4: message bits per frame.
- K, 3: encoder constraint length; tail length is K-1.
- DIV, 25: system clocks per encoder bit (bit-tick period); legal range is DIV ≥ 1.
- N (derived, not overridable): DATA_W+K-1 bits per frame; codeword width is 2N.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to encode data_in; honoured only in IDLE.
- data_in  in  DATA_W  message; captured in the start cycle.
- busy  out  1  high from the cycle after an accepted start until the codeword handshake completes.
- enc_clr  out  1  one-cycle synchronous clear of the encoder shift register.
- enc_en  out  1  one-cycle encoder shift enable (bit-tick).
- enc_din  out  1  bit presented to the encoder; valid while enc_en=1.
- enc_tail  out  1  high while tail bits are being sent.
- enc_y  in  2  encoder output for (enc_din, current encoder state), combinational; y[1]=g0, y[0]=g1.
- cw_out  out  2N  codeword; first-sent pair in the MSBs.
- cw_valid  out  1  codeword available.
- cw_ready  in  1  downstream accepts the codeword.
- frame_done  out  1  one-cycle pulse in the cycle the handshake completes.

## Operation
- States:
  - IDLE: start → CLEAR, latch data_in into the shift register.
  - CLEAR: enc_clr=1 for exactly one cycle; the tick counter loads 0 → SEND.
  - SEND: on each tick, issue enc_en with enc_din = message MSB, shift left, bit_cnt++. After DATA_W ticks → TAIL; if K=1, go straight to OUT.
  - TAIL: enc_din=0, enc_tail=1; after K-1 ticks → OUT.
  - OUT: cw_valid=1 and cw_out stable until cw_ready; on the handshake cycle frame_done=1 → IDLE.
- Tick counter: counts 0..DIV-1 in SEND/TAIL; enc_en when count==DIV-1, then wraps to 0. With DIV=1, enc_en is high every SEND/TAIL cycle.
- Capture: on every enc_en cycle, enc_y goes into the codeword shift register (shift left by 2, insert at LSBs). After N ticks, pair i sits at cw_out[2N-1-2i -: 2].
- start outside IDLE is ignored, with no queueing. A start coinciding with frame_done is also ignored (the FSM is in OUT that cycle).
- cw_ready outside OUT is ignored.
- rst at any point forces IDLE next cycle and aborts any frame. Reset does not pulse enc_clr; the encoder has its own reset.
- Reset value of every output is 0: busy, enc_clr, enc_en, enc_din, enc_tail, cw_valid, frame_done, cw_out.

## Timing
- Start accepted at cycle t: busy=1 and enc_clr=1 at t+1.
- First enc_en at t+1+DIV; subsequent enc_en every DIV cycles; last at t+1+N·DIV.
- cw_valid rises at t+2+N·DIV.
- With cw_ready held high, frame_done fires at t+2+N·DIV and busy drops at t+3+N·DIV.
- enc_din and enc_tail are registered and stable for the whole tick period before and during enc_en.
- Back-to-back frames: the next start is accepted at the earliest in the cycle after frame_done, giving a frame period of N·DIV+3 cycles.

## Structure
- Package conv_pkg holds:
  - DATA_W and K defaults
  - the state enum (IDLE, CLEAR, SEND, TAIL, OUT)
  - the frame-length function N(DATA_W,K)
  - the generator constants G0=3'b111 and G1=3'b101, shared with the encoder and the decoder
- One sub-module, conv_tick_gen: the DIV counter with a synchronous clear input and a tick output.

## Test plan
- Golden frame: DATA_W=4, K=3, DIV=1, (7,5) encoder model attached, data_in=4'b1101. Expect 6 enc_en pulses with enc_din sequence 1,1,0,1,0,0, enc_tail high on the last two, and cw_out=12'hD4B (11 01 01 00 10 11) with cw_valid at t+8.
- DIV=25, same data: enc_en at t+26, t+51, …, t+151; cw_valid at t+152; no enc_en between ticks.
- Backpressure: hold cw_ready=0 for 40 cycles after cw_valid. cw_out must stay stable, busy=1, and no extra enc_en; frame_done pulses exactly once when cw_ready rises.
- Start while busy: pulse start with data_in=4'b0000 mid-SEND. The codeword must still be 12'hD4B and no second frame starts.
- Reset mid-TAIL: assert rst for one cycle. All outputs are 0 the next cycle and the FSM is in IDLE. A following start with 4'b1101 yields 12'hD4B, with enc_clr seen before the first enc_en.
- Back-to-back frames: data 4'b1101 then 4'b0000 with cw_ready=1. The codewords are 12'hD4B then 12'h000, and the second start is accepted only after frame_done.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_pkg: shared types and constants for the rate-1/2 convolutional codec. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package conv_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int K_DEF      = 3;

    // Generator polynomials, tap order {d(n), d(n-1), d(n-2)}.
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SEND  = 3'd2,
        TAIL  = 3'd3,
        OUT   = 3'd4
    } state_t;

    function automatic int frame_len(input int data_w, input int k);
        return data_w + k - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_tick_gen: modulo-DIV cycle counter producing a one-cycle bit tick.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_tick_gen #(
    parameter int DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_frame_sequencer: feeds a message plus flush tail into the encoder and |
// | hands the collected codeword downstream. Revision: 1.0                     |
// +----------------------------------------------------------------------------+
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int K      = K_DEF,
    parameter  int DIV    = 25,
    localparam int N      = frame_len(DATA_W, K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              busy_o,
    output logic              enc_clr_o,
    output logic              enc_en_o,
    output logic              enc_din_o,
    output logic              enc_tail_o,
    input  logic [1:0]        enc_y_i,
    output logic [2*N-1:0]    cw_out_o,
    output logic              cw_valid_o,
    input  logic              cw_ready_i,
    output logic              frame_done_o
);

    localparam int CW_W = 2 * N;
    localparam int BC_W = $clog2(N + 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] msg_q, msg_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              tick;
    logic              in_frame;

    assign in_frame = (state_q == SEND) || (state_q == TAIL);

    conv_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == CLEAR),
        .en_i   (in_frame),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        cw_d      = cw_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    msg_d   = data_in_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cw_d      = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND, TAIL: begin
                if (tick) begin
                    // Zeros shift in behind the message, so the tail bits come for free.
                    msg_d     = msg_q << 1;
                    cw_d      = (cw_q << 2) | CW_W'(enc_y_i);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BC_W'(N - 1)) begin
                        state_d = OUT;
                    end else if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        state_d = TAIL;
                    end
                end
            end
            OUT: begin
                if (cw_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            msg_q     <= '0;
            cw_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            cw_q      <= cw_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign enc_clr_o    = (state_q == CLEAR);
    assign enc_en_o     = tick;
    assign enc_din_o    = (state_q == SEND) && msg_q[DATA_W-1];
    assign enc_tail_o   = (state_q == TAIL);
    assign cw_out_o     = cw_q;
    assign cw_valid_o   = (state_q == OUT);
    assign frame_done_o = (state_q == OUT) && cw_ready_i;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_frame_sequencer: directed bench, DIV=1 and DIV=25 instances each   |
// | driving a (7,5) encoder model. Revision: 1.0                               |
// +----------------------------------------------------------------------------+
module tb_conv_frame_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a, ready_a, busy_a, clr_a, en_a, din_a, tail_a, valid_a, fd_a;
    logic [3:0]  data_a;
    logic [1:0]  y_a, s_a;
    logic [11:0] cw_a;
    logic        start_b, ready_b, busy_b, clr_b, en_b, din_b, tail_b, valid_b, fd_b;
    logic [3:0]  data_b;
    logic [1:0]  y_b, s_b;
    logic [11:0] cw_b;

    conv_frame_sequencer #(.DATA_W(4), .K(3), .DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .data_in_i(data_a), .busy_o(busy_a),
        .enc_clr_o(clr_a), .enc_en_o(en_a), .enc_din_o(din_a), .enc_tail_o(tail_a),
        .enc_y_i(y_a), .cw_out_o(cw_a), .cw_valid_o(valid_a), .cw_ready_i(ready_a),
        .frame_done_o(fd_a)
    );

    conv_frame_sequencer #(.DATA_W(4), .K(3), .DIV(25)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .data_in_i(data_b), .busy_o(busy_b),
        .enc_clr_o(clr_b), .enc_en_o(en_b), .enc_din_o(din_b), .enc_tail_o(tail_b),
        .enc_y_i(y_b), .cw_out_o(cw_b), .cw_valid_o(valid_b), .cw_ready_i(ready_b),
        .frame_done_o(fd_b)
    );

    // (7,5) encoder: state {d(n-1), d(n-2)}, y = {g0, g1}.
    assign y_a = {din_a ^ s_a[1] ^ s_a[0], din_a ^ s_a[0]};
    assign y_b = {din_b ^ s_b[1] ^ s_b[0], din_b ^ s_b[0]};

    always @(posedge clk) begin
        if (rst || clr_a)  s_a <= 2'b00;
        else if (en_a)     s_a <= {din_a, s_a[1]};
        if (rst || clr_b)  s_b <= 2'b00;
        else if (en_b)     s_b <= {din_b, s_b[1]};
    end

    int en_qa[$], clr_qa[$], fd_qa[$], en_qb[$], clr_qb[$], fd_qb[$];
    bit din_qa[$], tail_qa[$];

    always @(negedge clk) begin
        if (en_a) begin
            en_qa.push_back(cyc);
            din_qa.push_back(din_a);
            tail_qa.push_back(tail_a);
        end
        if (clr_a) clr_qa.push_back(cyc);
        if (fd_a)  fd_qa.push_back(cyc);
        if (en_b)  en_qb.push_back(cyc);
        if (clr_b) clr_qb.push_back(cyc);
        if (fd_b)  fd_qb.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int at_or(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    function automatic logic [5:0] pack6(input bit q[$], input int base);
        logic [5:0] v = '0;
        for (int i = 0; i < 6; i++) begin
            v = {v[4:0], (base + i < q.size()) ? q[base + i] : 1'b0};
        end
        return v;
    endfunction

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_a_pulse(input logic [3:0] d, output int t);
        @(posedge clk); #1;
        start_a = 1'b1; data_a = d; t = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic start_b_pulse(input logic [3:0] d, output int t);
        @(posedge clk); #1;
        start_b = 1'b1; data_b = d; t = cyc;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_valid_a(input string tag, output int vc);
        vc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid_a) begin vc = cyc; break; end
        end
        check({tag, "_valid_seen"}, (vc >= 0), 1'b1);
        #1;
    endtask

    task automatic wait_valid_b(input string tag, output int vc);
        vc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid_b) begin vc = cyc; break; end
        end
        check({tag, "_valid_seen"}, (vc >= 0), 1'b1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, vc, base, cbase, fbase, n, bad, rc;
        rst = 1'b1;
        start_a = 1'b0; data_a = '0; ready_a = 1'b1;
        start_b = 1'b0; data_b = '0; ready_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs_a", {busy_a, clr_a, en_a, din_a, tail_a, valid_a, fd_a, cw_a}, '0);
        check("rst_outs_b", {busy_b, clr_b, en_b, din_b, tail_b, valid_b, fd_b, cw_b}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        goto(cyc + 2);

        // Golden frame, DIV=1.
        base = en_qa.size(); cbase = clr_qa.size();
        start_a_pulse(4'b1101, t);
        wait_valid_a("a1", vc);
        check("a1_valid_cyc", vc, t + 8);
        check("a1_cw", cw_a, 12'hD4B);
        check("a1_en_cnt", en_qa.size() - base, 6);
        check("a1_din_seq", pack6(din_qa, base), 6'b110100);
        check("a1_tail_seq", pack6(tail_qa, base), 6'b000011);
        check("a1_clr_cyc", at_or(clr_qa, cbase), t + 1);
        check("a1_first_en", at_or(en_qa, base), t + 2);
        check("a1_fd_cyc", at_or(fd_qa, fd_qa.size() - 1), vc);
        @(negedge clk);
        check("a1_busy_drop", busy_a, 1'b0);

        // Start while busy is ignored.
        base = en_qa.size();
        start_a_pulse(4'b1101, t);
        goto(t + 3);
        start_a = 1'b1; data_a = 4'b0000;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_valid_a("a2", vc);
        check("a2_cw", cw_a, 12'hD4B);
        check("a2_en_cnt", en_qa.size() - base, 6);
        n = en_qa.size();
        repeat (20) @(negedge clk);
        #1;
        check("a2_no_second", en_qa.size() - n, 0);
        check("a2_idle", busy_a, 1'b0);

        // Reset mid-TAIL, then a clean frame.
        start_a_pulse(4'b1101, t);
        goto(t + 6);
        rst = 1'b1;
        @(negedge clk);
        check("a3_in_tail", tail_a, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("a3_rst_outs", {busy_a, clr_a, en_a, din_a, tail_a, valid_a, fd_a, cw_a}, '0);
        base = en_qa.size(); cbase = clr_qa.size();
        start_a_pulse(4'b1101, t);
        wait_valid_a("a3", vc);
        check("a3_cw", cw_a, 12'hD4B);
        check("a3_clr_before_en", at_or(clr_qa, cbase) < at_or(en_qa, base), 1'b1);

        // Back-to-back, start held high through the first frame.
        cbase = clr_qa.size();
        goto(cyc + 1);
        start_a = 1'b1; data_a = 4'b1101; t1 = cyc;
        @(posedge clk); #1;
        data_a = 4'b0000;
        wait_valid_a("a4a", vc);
        check("a4_first_valid", vc, t1 + 8);
        check("a4_first_cw", cw_a, 12'hD4B);
        @(negedge clk);
        check("a4_idle_gap", busy_a, 1'b0);
        goto(t1 + 10);
        start_a = 1'b0;
        wait_valid_a("a4b", vc);
        check("a4_second_valid", vc, t1 + 17);
        check("a4_second_cw", cw_a, 12'h000);
        check("a4_clr_cnt", clr_qa.size() - cbase, 2);
        check("a4_second_clr", at_or(clr_qa, cbase + 1), t1 + 10);

        // DIV=25 timing plus backpressure.
        base = en_qb.size(); fbase = fd_qb.size();
        start_b_pulse(4'b1101, t);
        wait_valid_b("b1", vc);
        check("b1_valid_cyc", vc, t + 152);
        check("b1_cw", cw_b, 12'hD4B);
        check("b1_en_cnt", en_qb.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b1_en%0d_cyc", i), at_or(en_qb, base + i), t + 26 + 25 * i);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cw_b !== 12'hD4B || busy_b !== 1'b1 || valid_b !== 1'b1 || fd_b !== 1'b0) bad++;
        end
        #1;
        check("b1_bp_hold", bad, 0);
        check("b1_bp_no_en", en_qb.size() - base, 6);
        check("b1_bp_no_fd", fd_qb.size() - fbase, 0);
        @(posedge clk); #1;
        ready_b = 1'b1; rc = cyc;
        @(negedge clk); #1;
        check("b1_fd_cyc", at_or(fd_qb, fbase), rc);
        @(negedge clk);
        check("b1_busy_drop", busy_b, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        check("b1_fd_once", fd_qb.size() - fbase, 1);

        // Start while busy, DIV=25.
        base = en_qb.size();
        start_b_pulse(4'b1101, t);
        goto(t + 60);
        start_b = 1'b1; data_b = 4'b0000;
        @(posedge clk); #1;
        start_b = 1'b0;
        wait_valid_b("b2", vc);
        check("b2_valid_cyc", vc, t + 152);
        check("b2_cw", cw_b, 12'hD4B);
        repeat (200) @(negedge clk);
        #1;
        check("b2_no_second", en_qb.size() - base, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
